// File: rtl/zx_mem_pkg.sv
// Shared memory-subsystem definitions: SRAM geometry, arbiter states and the
// location of the stored scandoubler settings byte.
package zx_mem_pkg;
  localparam int SRAM_AW = 21;
  localparam logic [SRAM_AW-1:0] BOOT_ADDR = 21'h08FD5;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DMA  = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;
endpackage

// File: rtl/sram_arbiter.sv
// Single external SRAM port shared by the Z80 memory path (zero-latency pass-through)
// and a byte-wide DMA requester; reads the scandoubler settings byte at power-up.
import zx_mem_pkg::*;

module sram_arbiter #(
  parameter logic [SRAM_AW-1:0] BOOT_ADDR  = zx_mem_pkg::BOOT_ADDR,
  parameter int                 BOOT_WAIT  = 8,
  parameter int                 ACC_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               power,
  output logic               ready,
  output logic [1:0]         scndbl,
  input  logic [SRAM_AW-1:0] cpuA,
  input  logic [7:0]         cpuD,
  output logic [7:0]         cpuQ,
  input  logic               cpuWr,
  input  logic               cpuRd,
  output logic               waitn,
  input  logic               dmaReq,
  input  logic               dmaWr,
  input  logic [SRAM_AW-1:0] dmaA,
  input  logic [7:0]         dmaD,
  output logic [7:0]         dmaQ,
  output logic               dmaAck,
  output logic               sramWe,
  inout  wire  [7:0]         sramDQ,
  output logic [SRAM_AW-1:0] sramA
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_WAIT - 1);
  localparam logic [3:0] ACC_LAST  = 4'(ACC_CYCLES - 1);

  arb_state_t         r_state, w_next;
  logic [7:0]         r_boot_cnt;
  logic [3:0]         r_cyc;
  logic               r_ready;
  logic [1:0]         r_scndbl;
  logic [7:0]         r_dma_q;
  logic               r_dma_wr;
  logic [SRAM_AW-1:0] r_dma_a;
  logic [7:0]         r_dma_d;

  logic               w_cpu_req;
  logic               w_last;
  logic               w_accept;
  logic               w_dq_oe;
  logic [7:0]         w_dq_out;
  logic [SRAM_AW-1:0] w_sram_a;
  logic               w_sram_we;

  assign w_cpu_req = cpuRd | cpuWr;
  assign w_last    = (r_state == ST_DMA) && (r_cyc == ACC_LAST);
  assign w_accept  = (r_state == ST_IDLE) && !w_cpu_req && dmaReq;

  always_comb begin
    w_next    = r_state;
    w_sram_a  = BOOT_ADDR;
    w_sram_we = 1'b1;
    w_dq_oe   = 1'b0;
    w_dq_out  = cpuD;
    case (r_state)
      ST_BOOT: begin
        if (power && (r_boot_cnt == BOOT_LAST)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_sram_a = cpuA;
        if (w_cpu_req) begin
          // Both strobes high resolves to a write.
          w_sram_we = !cpuWr;
          w_dq_oe   = cpuWr;
        end else if (dmaReq) begin
          w_next = ST_DMA;
        end
      end
      ST_DMA: begin
        w_sram_a  = r_dma_a;
        w_dq_oe   = r_dma_wr;
        w_dq_out  = r_dma_d;
        // WE held off on the first and last cycle for address setup/hold.
        w_sram_we = !(r_dma_wr && (r_cyc != 4'd0) && (r_cyc != ACC_LAST));
        if (w_last) w_next = ST_TURN;
      end
      ST_TURN: begin
        w_sram_a = r_dma_a;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= 8'd0;
      r_cyc      <= 4'd0;
      r_ready    <= 1'b0;
      r_scndbl   <= 2'b00;
      r_dma_q    <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == ST_BOOT) begin
        if (!power) begin
          r_boot_cnt <= 8'd0;
        end else if (r_boot_cnt == BOOT_LAST) begin
          r_scndbl <= sramDQ[1:0];
          r_ready  <= 1'b1;
        end else begin
          r_boot_cnt <= r_boot_cnt + 8'd1;
        end
      end
      if (w_accept) r_cyc <= 4'd0;
      else if (r_state == ST_DMA) r_cyc <= r_cyc + 4'd1;
      if (w_last && !r_dma_wr) r_dma_q <= sramDQ;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_dma_wr <= dmaWr;
      r_dma_a  <= dmaA;
      r_dma_d  <= dmaD;
    end
  end

  assign sramDQ = w_dq_oe ? w_dq_out : 8'hzz;
  assign sramA  = w_sram_a;
  assign sramWe = w_sram_we;
  assign cpuQ   = sramDQ;
  assign waitn  = !(w_cpu_req && ((r_state == ST_DMA) || (r_state == ST_TURN)));
  assign dmaAck = w_last;
  // Read data is visible during the ack cycle and held afterwards.
  assign dmaQ   = (w_last && !r_dma_wr) ? sramDQ : r_dma_q;
  assign ready  = r_ready;
  assign scndbl = r_scndbl;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small byte-wide SRAM model on the shared bus.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int          BOOT_WAIT  = 8;
  localparam int          ACC_CYCLES = 4;
  localparam logic [20:0] BADDR      = 21'h08FD5;

  logic        clock = 1'b0;
  logic        reset, power;
  logic        ready;
  logic [1:0]  scndbl;
  logic [20:0] cpuA;
  logic [7:0]  cpuD, cpuQ;
  logic        cpuWr, cpuRd, waitn;
  logic        dmaReq, dmaWr;
  logic [20:0] dmaA;
  logic [7:0]  dmaD, dmaQ;
  logic        dmaAck, sramWe;
  wire  [7:0]  sramDQ;
  logic [20:0] sramA;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model: 4K bytes aliased on the low address bits, settings byte at BADDR.
  logic [7:0] mem [0:4095];
  logic       mdl_en;
  logic [7:0] mdl_q;
  assign mdl_q  = (sramA == BADDR) ? 8'hA2 : mem[sramA[11:0]];
  assign sramDQ = (mdl_en && sramWe) ? mdl_q : 8'hzz;
  always @(posedge clock) if (!sramWe) mem[sramA[11:0]] <= sramDQ;

  always #5 clock = ~clock;

  sram_arbiter #(.BOOT_ADDR(BADDR), .BOOT_WAIT(BOOT_WAIT), .ACC_CYCLES(ACC_CYCLES)) dut (
    .clock(clock), .reset(reset), .power(power), .ready(ready), .scndbl(scndbl),
    .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuWr(cpuWr), .cpuRd(cpuRd), .waitn(waitn),
    .dmaReq(dmaReq), .dmaWr(dmaWr), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
    .sramWe(sramWe), .sramDQ(sramDQ), .sramA(sramA)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; power = 1'b0; cpuRd = 1'b1; cpuWr = 1'b0; cpuA = 21'h0; cpuD = 8'h0;
    dmaReq = 1'b0; dmaWr = 1'b0; dmaA = 21'h0; dmaD = 8'h0; mdl_en = 1'b1;
    step(); step();
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b0 || scndbl !== 2'b00) begin
      n_fail++; $display("FAIL reset_status ready=%b scndbl=%b want 0/00", ready, scndbl);
    end
    n_checks++;
    if (dmaAck !== 1'b0 || dmaQ !== 8'h00 || waitn !== 1'b1) begin
      n_fail++; $display("FAIL reset_dma ack=%b q=%h waitn=%b want 0/00/1", dmaAck, dmaQ, waitn);
    end
    n_checks++;
    if (sramWe !== 1'b1 || sramA !== BADDR) begin
      n_fail++; $display("FAIL reset_bus we=%b a=%h want 1/%h", sramWe, sramA, BADDR);
    end
    cpuRd = 1'b0;
  endtask

  task automatic test_boot();
    bit bad_addr = 0;
    bit bad_rdy  = 0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ready !== 1'b0) bad_rdy = 1;
      if (sramA !== BADDR) bad_addr = 1;
    end
    n_checks++;
    if (bad_rdy) begin n_fail++; $display("FAIL boot_power_low ready rose while power=0 want 0"); end
    power = 1'b1;
    for (int i = 1; i <= BOOT_WAIT; i++) begin
      if (i < BOOT_WAIT && sramA !== BADDR) bad_addr = 1;
      step();
      n_checks++;
      if (ready !== (i == BOOT_WAIT)) begin
        n_fail++; $display("FAIL boot_ready clk=%0d ready=%b want %b", i, ready, (i == BOOT_WAIT));
      end
    end
    n_checks++;
    if (bad_addr) begin n_fail++; $display("FAIL boot_addr sramA left %h during boot", BADDR); end
    n_checks++;
    if (scndbl !== 2'b10) begin n_fail++; $display("FAIL boot_scndbl got=%b want 10", scndbl); end
  endtask

  task automatic test_cpu_passthru();
    cpuWr = 1'b1; cpuA = 21'h04000; cpuD = 8'h5A; mdl_en = 1'b0;
    @(negedge clock);
    n_checks++;
    if (sramWe !== 1'b0 || sramA !== 21'h04000 || waitn !== 1'b1 || sramDQ !== 8'h5A) begin
      n_fail++; $display("FAIL cpu_write we=%b a=%h waitn=%b dq=%h want 0/04000/1/5a", sramWe, sramA, waitn, sramDQ);
    end
    step();
    cpuWr = 1'b0; cpuRd = 1'b1; mdl_en = 1'b1; power = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mem[12'h000] !== 8'h5A) begin n_fail++; $display("FAIL cpu_mem got=%h want 5a", mem[12'h000]); end
    n_checks++;
    if (cpuQ !== 8'h5A || sramWe !== 1'b1 || waitn !== 1'b1) begin
      n_fail++; $display("FAIL cpu_read q=%h we=%b waitn=%b want 5a/1/1", cpuQ, sramWe, waitn);
    end
    step();
    cpuRd = 1'b0;
    step();
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL power_drop ready=%b want 1", ready); end
    power = 1'b1;
  endtask

  task automatic test_dma_wr_rd();
    dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h12345; dmaD = 8'hC3; mdl_en = 1'b0;
    for (int c = 0; c < ACC_CYCLES; c++) begin
      step();
      @(negedge clock);
      n_checks++;
      if (sramWe !== !(c == 1 || c == 2) || dmaAck !== (c == 3) || sramA !== 21'h12345 || sramDQ !== 8'hC3) begin
        n_fail++; $display("FAIL dma_wr_cyc%0d we=%b ack=%b a=%h dq=%h want %b/%b/12345/c3",
                           c, sramWe, dmaAck, sramA, sramDQ, !(c == 1 || c == 2), (c == 3));
      end
    end
    step();
    dmaWr = 1'b0; mdl_en = 1'b1;
    @(negedge clock);
    n_checks++;
    if (dmaAck !== 1'b0 || sramWe !== 1'b1 || mem[12'h345] !== 8'hC3) begin
      n_fail++; $display("FAIL dma_turn ack=%b we=%b mem=%h want 0/1/c3", dmaAck, sramWe, mem[12'h345]);
    end
    step();
    @(negedge clock);
    n_checks++;
    if (dmaAck !== 1'b0 || sramA !== cpuA) begin
      n_fail++; $display("FAIL dma_idle_gap ack=%b a=%h want 0/%h", dmaAck, sramA, cpuA);
    end
    for (int c = 0; c < ACC_CYCLES; c++) begin
      step();
      @(negedge clock);
      n_checks++;
      if (sramWe !== 1'b1 || dmaAck !== (c == 3) || sramA !== 21'h12345) begin
        n_fail++; $display("FAIL dma_rd_cyc%0d we=%b ack=%b a=%h want 1/%b/12345", c, sramWe, dmaAck, sramA, (c == 3));
      end
      if (c == 3) begin
        n_checks++;
        if (dmaQ !== 8'hC3) begin n_fail++; $display("FAIL dma_rd_ackq got=%h want c3", dmaQ); end
        dmaReq = 1'b0;
      end
    end
    step();
    n_checks++;
    if (dmaQ !== 8'hC3 || dmaAck !== 1'b0) begin
      n_fail++; $display("FAIL dma_rd_hold q=%h ack=%b want c3/0", dmaQ, dmaAck);
    end
    step();
  endtask

  task automatic test_conflict();
    dmaReq = 1'b1; dmaWr = 1'b0; dmaA = 21'h12345; cpuA = 21'h04000; mdl_en = 1'b1;
    step();
    @(negedge clock);
    n_checks++;
    if (waitn !== 1'b1) begin n_fail++; $display("FAIL conf_cyc0 waitn=%b want 1", waitn); end
    step();
    cpuRd = 1'b1;
    for (int c = 1; c < ACC_CYCLES; c++) begin
      @(negedge clock);
      n_checks++;
      if (waitn !== 1'b0 || sramA !== 21'h12345 || dmaAck !== (c == 3)) begin
        n_fail++; $display("FAIL conf_cyc%0d waitn=%b a=%h ack=%b want 0/12345/%b", c, waitn, sramA, dmaAck, (c == 3));
      end
      if (c == 3) dmaReq = 1'b0;
      step();
    end
    @(negedge clock);
    n_checks++;
    if (waitn !== 1'b0 || sramWe !== 1'b1) begin
      n_fail++; $display("FAIL conf_turn waitn=%b we=%b want 0/1", waitn, sramWe);
    end
    step();
    @(negedge clock);
    n_checks++;
    if (waitn !== 1'b1 || sramA !== 21'h04000 || cpuQ !== 8'h5A || dmaQ !== 8'hC3) begin
      n_fail++; $display("FAIL conf_cpu waitn=%b a=%h q=%h dq=%h want 1/04000/5a/c3", waitn, sramA, cpuQ, dmaQ);
    end
    step();
    cpuRd = 1'b0;
  endtask

  task automatic test_priority();
    bit got_ack = 0;
    mdl_en = 1'b0;
    cpuWr = 1'b1; cpuA = 21'h04001; cpuD = 8'h77;
    dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h00100; dmaD = 8'h99;
    @(negedge clock);
    n_checks++;
    if (sramWe !== 1'b0 || sramA !== 21'h04001) begin
      n_fail++; $display("FAIL prio_cpu we=%b a=%h want 0/04001", sramWe, sramA);
    end
    step();
    cpuWr = 1'b0;
    @(negedge clock);
    n_checks++;
    if (sramWe !== 1'b1 || sramA !== 21'h04001 || mem[12'h001] !== 8'h77) begin
      n_fail++; $display("FAIL prio_idle we=%b a=%h mem=%h want 1/04001/77", sramWe, sramA, mem[12'h001]);
    end
    step();
    n_checks++;
    if (sramA !== 21'h00100) begin n_fail++; $display("FAIL prio_accept a=%h want 00100", sramA); end
    for (int c = 0; c < 10 && !got_ack; c++) begin
      @(negedge clock);
      if (dmaAck) begin got_ack = 1; dmaReq = 1'b0; end
      step();
    end
    n_checks++;
    if (!got_ack || mem[12'h100] !== 8'h99) begin
      n_fail++; $display("FAIL prio_dma ack_seen=%b mem=%h want 1/99", got_ack, mem[12'h100]);
    end
    step();
  endtask

  task automatic test_reset_mid_dma();
    bit saw_ack = 0;
    dmaReq = 1'b1; dmaWr = 1'b1; dmaA = 21'h00200; dmaD = 8'h55; mdl_en = 1'b0;
    step();
    step();
    @(negedge clock);
    n_checks++;
    if (sramWe !== 1'b0) begin n_fail++; $display("FAIL mid_cyc1 we=%b want 0", sramWe); end
    reset = 1'b0;
    step();
    mdl_en = 1'b1;
    n_checks++;
    if (sramWe !== 1'b1 || dmaAck !== 1'b0 || ready !== 1'b0 || sramA !== BADDR || dmaQ !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset we=%b ack=%b ready=%b a=%h q=%h want 1/0/0/%h/00",
                         sramWe, dmaAck, ready, sramA, dmaQ, BADDR);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (dmaAck) saw_ack = 1;
      step();
    end
    n_checks++;
    if (saw_ack || ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_noack ack_seen=%b ready=%b want 0/0", saw_ack, ready);
    end
    dmaReq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_cpu_passthru();
    test_dma_wr_rd();
    test_conflict();
    test_priority();
    test_reset_mid_dma();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the single external SRAM port and shares it between two requesters: the Z80 memory path and a byte-wide DMA requester (snapshot/ROM loader).
- The Z80 side arrives already decoded and paged: physical address, write strobe and read strobe.
- At power-up the block reads the scandoubler settings byte from SRAM before releasing `ready`. This replaces the ad-hoc settings read in the memory block.

Parameters:
- BOOT_ADDR, 21'h08FD5, SRAM address of the stored scandoubler settings byte.
- BOOT_WAIT, 8, clocks the boot address is held before the settings byte is latched (1..255).
- ACC_CYCLES, 4, clocks per DMA access (3..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- power  in  1  board power-good; the boot read starts only once it is high.
- ready  out  1  high once the boot read is complete.
- scndbl  out  2  scandoubler setting, bits [1:0] of the boot byte.
- cpuA  in  21  CPU physical SRAM address, already paged.
- cpuD  in  8  CPU write data.
- cpuQ  out  8  CPU read data, combinational from sramDQ.
- cpuWr  in  1  active-high CPU SRAM write request (mreq & wr & writable region).
- cpuRd  in  1  active-high CPU SRAM read request.
- waitn  out  1  Z80 WAIT, active-low.
- dmaReq  in  1  DMA request, level, held until ack.
- dmaWr  in  1  1 = write, 0 = read; sampled on accept.
- dmaA  in  21  DMA address; sampled on accept.
- dmaD  in  8  DMA write data; sampled on accept.
- dmaQ  out  8  DMA read data; valid from the dmaAck cycle until the next accept.
- dmaAck  out  1  one-clock completion pulse.
- sramWe  out  1  active-low SRAM write enable.
- sramDQ  inout  8  SRAM data bus.
- sramA  out  21  SRAM address.

Behaviour:
- States: BOOT, IDLE, DMA, TURN.
- Reset (`reset` = 0 at a clock edge):
  - state = BOOT, boot counter = 0.
  - ready = 0, scndbl = 2'b00.
  - dmaAck = 0, dmaQ = 8'h00, waitn = 1.
  - sramWe = 1 and sramDQ is Z in every state on reset.
- BOOT:
  - sramA = BOOT_ADDR, sramWe = 1; CPU requests are ignored and waitn = 1.
  - While power = 0 the counter is held at 0.
  - Otherwise the counter increments. When it reaches BOOT_WAIT-1, scndbl <= sramDQ[1:0], ready <= 1 and the state goes to IDLE.
  - dmaReq is not accepted in BOOT.
- IDLE, CPU requesting (cpuRd | cpuWr):
  - CPU pass-through, zero latency: sramA = cpuA, sramWe = !cpuWr.
  - sramDQ is driven with cpuD only while cpuWr = 1, otherwise Z.
  - cpuQ = sramDQ.
- IDLE, CPU idle and dmaReq = 1:
  - Accept the request: register dmaWr, dmaA and dmaD; cycle counter = 0; go to DMA.
  - The CPU has priority in the same cycle: no accept while cpuRd | cpuWr.
- DMA:
  - sramA = registered address for all ACC_CYCLES clocks.
  - On a write, sramDQ is driven for all cycles, and sramWe = 0 only on cycles 1..ACC_CYCLES-2, giving address setup/hold margin.
  - On the last cycle: a read latches dmaQ <= sramDQ; dmaAck = 1 for exactly this one clock; go to TURN.
- TURN:
  - One clock with sramWe = 1 and DQ = Z, then IDLE.
  - dmaReq still high in IDLE after the ack counts as a new request.
- CPU request arriving during DMA or TURN:
  - waitn = 0 combinationally while (cpuRd | cpuWr) & state != IDLE.
  - The CPU is served in the first IDLE cycle, so waitn returns to 1.
  - The SRAM is never driven by both requesters.
- reset = 0 in the middle of a DMA access: the access is abandoned with no dmaAck; sramWe = 1 on the same edge.
- power falling after boot: no effect; only reset re-enters BOOT.
- cpuRd and cpuWr both high: treated as a write.

Decomposition:
- Shared package `zx_mem_pkg`:
  - state enum (BOOT, IDLE, DMA, TURN);
  - SRAM address width 21;
  - BOOT_ADDR constant, also used by the memory block.
- No sub-module: the tristate and address muxes stay inline in the one FSM module.

Test Plan:
- Boot: reset low for 2 clocks, power = 0 for 20 clocks, then 1, with sramDQ modelled as 8'hA2 at 0x08FD5 -> ready rises exactly BOOT_WAIT clocks after power; scndbl = 2'b10; sramA = 0x08FD5 throughout boot.
- CPU pass-through: cpuWr = 1, cpuA = 0x04000, cpuD = 8'h5A; then cpuRd at the same address -> sramWe low in the same cycle, model holds 8'h5A, cpuQ = 8'h5A combinationally, waitn stays 1.
- DMA write then read: dmaWr = 1, dmaA = 0x12345, dmaD = 8'hC3, then a read of 0x12345 ->
  - write: sramWe low for clocks 1..2 of 4; dmaAck one clock at clock 3;
  - read: dmaQ = 8'hC3; the accepts are separated by the TURN cycle.
- Conflict: cpuRd asserted one clock after a DMA accept -> waitn = 0 for the remaining 3 DMA clocks plus TURN; the CPU read completes in the next IDLE clock; no bus overlap is flagged by the model.
- Same-cycle priority: cpuWr and dmaReq rise together -> the CPU write completes first; the DMA is accepted the first clock the CPU strobes are low.
- Reset mid-DMA: assert reset on DMA cycle 1 of a write -> no dmaAck; sramWe = 1 and DQ = Z on that edge; state = BOOT; ready = 0.
